// File: rtl/id_issue_stage_pkg.sv
// Shared decode definitions for the ID/issue stage: RV32I opcodes, ALU-select
// codes, immediate formats and the combinational decoder.
package id_issue_stage_pkg;

    localparam logic [6:0] EXE_OP_IMM = 7'b0010011;
    localparam logic [6:0] EXE_OP     = 7'b0110011;
    localparam logic [6:0] EXE_LUI    = 7'b0110111;
    localparam logic [6:0] EXE_AUIPC  = 7'b0010111;
    localparam logic [6:0] EXE_JAL    = 7'b1101111;
    localparam logic [6:0] EXE_JALR   = 7'b1100111;
    localparam logic [6:0] EXE_BRANCH = 7'b1100011;
    localparam logic [6:0] EXE_LOAD   = 7'b0000011;
    localparam logic [6:0] EXE_STORE  = 7'b0100011;

    // alusel[4:3] class; CLS_SEL means alusel is a whole SEL_* code
    typedef enum logic [1:0] {
        CLS_SEL    = 2'b00,
        CLS_ALU    = 2'b01,
        CLS_BRANCH = 2'b10,
        CLS_LOAD   = 2'b11
    } alu_cls_e;

    localparam logic [4:0] SEL_NOP   = 5'd0;
    localparam logic [4:0] SEL_LUI   = 5'd1;
    localparam logic [4:0] SEL_AUIPC = 5'd2;
    localparam logic [4:0] SEL_JAL   = 5'd3;
    localparam logic [4:0] SEL_JALR  = 5'd4;
    localparam logic [4:0] SEL_SB    = 5'd5;
    localparam logic [4:0] SEL_SH    = 5'd6;
    localparam logic [4:0] SEL_SW    = 5'd7;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef struct packed {
        logic       re1;
        logic       re2;
        logic       we;
        logic [4:0] alusel;
        imm_fmt_e   fmt;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t       d;
        logic [2:0] f3;
        f3 = inst[14:12];
        d  = '{re1: 1'b0, re2: 1'b0, we: 1'b0, alusel: SEL_NOP, fmt: IMM_NONE};
        case (inst[6:0])
            EXE_OP_IMM: d = '{1'b1, 1'b0, 1'b1, {CLS_ALU, f3},    IMM_I};
            EXE_OP:     d = '{1'b1, 1'b1, 1'b1, {CLS_ALU, f3},    IMM_NONE};
            EXE_LUI:    d = '{1'b0, 1'b0, 1'b1, SEL_LUI,          IMM_U};
            EXE_AUIPC:  d = '{1'b0, 1'b0, 1'b1, SEL_AUIPC,        IMM_U};
            EXE_JAL:    d = '{1'b0, 1'b0, 1'b1, SEL_JAL,          IMM_J};
            EXE_JALR:   d = '{1'b1, 1'b0, 1'b1, SEL_JALR,         IMM_I};
            EXE_BRANCH: d = '{1'b1, 1'b1, 1'b0, {CLS_BRANCH, f3}, IMM_B};
            EXE_LOAD:   d = '{1'b1, 1'b0, 1'b1, {CLS_LOAD, f3},   IMM_I};
            EXE_STORE:
                if (f3 <= 3'b010)
                    d = '{1'b1, 1'b1, 1'b0, SEL_SB + {2'b00, f3}, IMM_S};
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] imm_gen(input imm_fmt_e fmt, input logic [31:0] inst);
        case (fmt)
            IMM_I:   return {{20{inst[31]}}, inst[31:20]};
            IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   return {inst[31:12], 12'b0};
            IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/id_issue_stage_fwd_mux.sv
// Per-source-operand resolver: immediate, x0, forwarding (lowest index wins)
// or regfile data; flags a hazard when the matching source is a load in flight.
module id_fwd_mux #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                      i_re,
    input  logic [REG_AW-1:0]         i_addr,
    input  logic [XLEN-1:0]           i_rf_data,
    input  logic [XLEN-1:0]           i_imm,
    input  logic [NUM_FWD-1:0]        i_fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] i_fwd_wd,
    input  logic [NUM_FWD*XLEN-1:0]   i_fwd_data,
    input  logic [NUM_FWD-1:0]        i_fwd_isload,
    output logic [XLEN-1:0]           o_opr,
    output logic                      o_hazard
);

    always_comb begin
        o_opr    = i_rf_data;
        o_hazard = 1'b0;
        if (!i_re) begin
            o_opr = i_imm;
        end else if (i_addr == '0) begin
            o_opr = '0;
        end else begin
            // Walk oldest to youngest so the lowest matching index is applied last
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (i_fwd_we[i] && i_fwd_wd[i*REG_AW +: REG_AW] == i_addr) begin
                    o_opr    = i_fwd_data[i*XLEN +: XLEN];
                    o_hazard = i_fwd_isload[i];
                end
            end
        end
    end

endmodule

// File: rtl/id_issue_stage.sv
// RV32I decode/operand-issue stage with a valid/ready ID/EX output register.
// Define ID_STALL_STATS_EN to add stall_cnt_o, a saturating load-use stall counter.
module id_issue_stage import id_issue_stage_pkg::*; #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [XLEN-1:0]           pc_i,
    input  logic [31:0]               inst_i,
    output logic                      rs1_re_o,
    output logic                      rs2_re_o,
    output logic [REG_AW-1:0]         rs1_addr_o,
    output logic [REG_AW-1:0]         rs2_addr_o,
    input  logic [XLEN-1:0]           rs1_data_i,
    input  logic [XLEN-1:0]           rs2_data_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
    input  logic [NUM_FWD-1:0]        fwd_isload_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [4:0]                alusel_o,
    output logic [XLEN-1:0]           opr1_o,
    output logic [XLEN-1:0]           opr2_o,
    output logic [XLEN-1:0]           opr3_o,
    output logic [XLEN-1:0]           opr4_o,
    output logic [REG_AW-1:0]         wd_o,
    output logic                      wreg_o,
    output logic                      hazard_o
`ifdef ID_STALL_STATS_EN
    ,
    output logic [31:0]               stall_cnt_o
`endif
);

    dec_t                   w_dec;
    logic [XLEN-1:0]        w_imm;
    logic [1:0]             w_re;
    logic [1:0]             w_hz;
    logic [1:0][REG_AW-1:0] w_addr;
    logic [1:0][XLEN-1:0]   w_rf;
    logic [1:0][XLEN-1:0]   w_opr;
    logic                   w_hazard;
    logic                   w_capture;

    logic                   r_valid;
    logic [4:0]             r_alusel;
    logic [XLEN-1:0]        r_opr1, r_opr2, r_opr3, r_opr4;
    logic [REG_AW-1:0]      r_wd;
    logic                   r_wreg;

    assign w_dec  = decode(inst_i);
    assign w_imm  = XLEN'($signed(imm_gen(w_dec.fmt, inst_i)));
    assign w_re   = {w_dec.re2, w_dec.re1};
    assign w_addr = {REG_AW'(inst_i[24:20]), REG_AW'(inst_i[19:15])};
    assign w_rf   = {rs2_data_i, rs1_data_i};

    for (genvar g = 0; g < 2; g++) begin : g_opr
        id_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_mux (
            .i_re         (w_re[g]),
            .i_addr       (w_addr[g]),
            .i_rf_data    (w_rf[g]),
            .i_imm        (w_imm),
            .i_fwd_we     (fwd_we_i),
            .i_fwd_wd     (fwd_wd_i),
            .i_fwd_data   (fwd_data_i),
            .i_fwd_isload (fwd_isload_i),
            .o_opr        (w_opr[g]),
            .o_hazard     (w_hz[g])
        );
    end

    assign rs1_re_o   = w_dec.re1;
    assign rs2_re_o   = w_dec.re2;
    assign rs1_addr_o = w_addr[0];
    assign rs2_addr_o = w_addr[1];

    assign w_hazard   = in_valid_i & (|w_hz);
    assign hazard_o   = w_hazard;
    assign in_ready_o = ~w_hazard & (~r_valid | out_ready_i);
    assign w_capture  = in_valid_i & in_ready_o & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_valid  <= 1'b0;
            r_alusel <= '0;
            r_opr1   <= '0;
            r_opr2   <= '0;
            r_opr3   <= '0;
            r_opr4   <= '0;
            r_wd     <= '0;
            r_wreg   <= 1'b0;
        end else if (w_capture) begin
            r_valid  <= 1'b1;
            r_alusel <= w_dec.alusel;
            r_opr1   <= w_opr[0];
            r_opr2   <= w_opr[1];
            r_opr3   <= (w_dec.re1 && w_dec.re2) ? w_imm : '0;
            r_opr4   <= pc_i;
            r_wd     <= w_dec.we ? REG_AW'(inst_i[11:7]) : '0;
            r_wreg   <= w_dec.we;
        end else if (out_ready_i) begin
            r_valid  <= 1'b0;
        end
    end

    assign out_valid_o = r_valid;
    assign alusel_o    = r_alusel;
    assign opr1_o      = r_opr1;
    assign opr2_o      = r_opr2;
    assign opr3_o      = r_opr3;
    assign opr4_o      = r_opr4;
    assign wd_o        = r_wd;
    assign wreg_o      = r_wreg;

`ifdef ID_STALL_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_hazard && r_stall_cnt != 32'hFFFF_FFFF)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
// Randomized scoreboard bench for id_issue_stage: a driver predicts each capture
// from an ISA-level model and queues it; a monitor pops and compares on transfer.
module tb_id_issue_stage;

    localparam int XLEN = 32, REG_AW = 5, NUM_FWD = 2;

    logic                      clk = 1'b0;
    logic                      rst, flush_i, in_valid_i, in_ready_o;
    logic [XLEN-1:0]           pc_i;
    logic [31:0]               inst_i;
    logic                      rs1_re_o, rs2_re_o;
    logic [REG_AW-1:0]         rs1_addr_o, rs2_addr_o;
    logic [XLEN-1:0]           rs1_data_i, rs2_data_i;
    logic [NUM_FWD-1:0]        fwd_we_i, fwd_isload_i;
    logic [NUM_FWD*REG_AW-1:0] fwd_wd_i;
    logic [NUM_FWD*XLEN-1:0]   fwd_data_i;
    logic                      out_valid_o, out_ready_i;
    logic [4:0]                alusel_o;
    logic [XLEN-1:0]           opr1_o, opr2_o, opr3_o, opr4_o;
    logic [REG_AW-1:0]         wd_o;
    logic                      wreg_o, hazard_o;
`ifdef ID_STALL_STATS_EN
    logic [31:0]               stall_cnt_o;
`endif

    id_issue_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .rs1_re_o(rs1_re_o), .rs2_re_o(rs2_re_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .fwd_we_i(fwd_we_i), .fwd_wd_i(fwd_wd_i), .fwd_data_i(fwd_data_i), .fwd_isload_i(fwd_isload_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .alusel_o(alusel_o),
        .opr1_o(opr1_o), .opr2_o(opr2_o), .opr3_o(opr3_o), .opr4_o(opr4_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .hazard_o(hazard_o)
`ifdef ID_STALL_STATS_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  alusel;
        logic [31:0] o1, o2, o3, o4;
        logic [4:0]  wd;
        logic        wreg;
    } bun_t;

    bun_t exp_q[$];
    int   nvec = 0, nerr = 0, nhaz = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        int sh = 32 - bits;
        return 32'($signed(v << sh) >>> sh);
    endfunction

    // ISA-level view of one operand: immediate, x0, first matching source, else regfile
    function automatic void resolve(input logic re, input logic [4:0] a, input logic [31:0] rf,
                                    input logic [31:0] imm, output logic [31:0] v, output logic hz);
        hz = 1'b0;
        v  = rf;
        if (!re) v = imm;
        else if (a == 5'd0) v = 32'd0;
        else
            for (int i = 0; i < NUM_FWD; i++)
                if (fwd_we_i[i] && fwd_wd_i[i*5 +: 5] == a) begin
                    v  = fwd_data_i[i*32 +: 32];
                    hz = fwd_isload_i[i];
                    break;
                end
    endfunction

    function automatic void model(input logic [31:0] inst, input logic [31:0] pc,
                                  input logic [31:0] r1, input logic [31:0] r2,
                                  output bun_t b, output logic re1, output logic re2, output logic hz);
        logic [2:0]  f3 = inst[14:12];
        logic [31:0] imm = 32'd0, v1, v2;
        logic        we = 1'b0, h1, h2;
        int          sel = 0;
        logic [31:0] immi = sx(inst >> 20, 12);
        re1 = 1'b0;
        re2 = 1'b0;
        case (inst[6:0])
            7'h13: begin re1 = 1; we = 1; sel = 8 + int'(f3); imm = immi; end
            7'h33: begin re1 = 1; re2 = 1; we = 1; sel = 8 + int'(f3); end
            7'h37: begin we = 1; sel = 1; imm = {inst[31:12], 12'b0}; end
            7'h17: begin we = 1; sel = 2; imm = {inst[31:12], 12'b0}; end
            7'h6f: begin we = 1; sel = 3;
                         imm = sx(32'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), 21); end
            7'h67: begin re1 = 1; we = 1; sel = 4; imm = immi; end
            7'h63: begin re1 = 1; re2 = 1; sel = 16 + int'(f3);
                         imm = sx(32'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), 13); end
            7'h03: begin re1 = 1; we = 1; sel = 24 + int'(f3); imm = immi; end
            7'h23: if (f3 < 3) begin re1 = 1; re2 = 1; sel = 5 + int'(f3);
                         imm = sx(32'({inst[31:25], inst[11:7]}), 12); end
            default: ;
        endcase
        resolve(re1, inst[19:15], r1, imm, v1, h1);
        resolve(re2, inst[24:20], r2, imm, v2, h2);
        hz = h1 | h2;
        b  = '{alusel: 5'(sel), o1: v1, o2: v2, o3: (re1 && re2) ? imm : 32'd0, o4: pc,
               wd: we ? inst[11:7] : 5'd0, wreg: we};
    endfunction

    task automatic setf(input logic [1:0] we, input logic [4:0] wd1, input logic [4:0] wd0,
                        input logic [31:0] d1, input logic [31:0] d0, input logic [1:0] ld);
        fwd_we_i     = we;
        fwd_wd_i     = {wd1, wd0};
        fwd_data_i   = {d1, d0};
        fwd_isload_i = ld;
    endtask

    // One cycle: drive at posedge+1, check combinational outputs, predict the edge
    task automatic step(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic v, input logic rdy, input logic fl, input logic rs);
        bun_t b;
        logic re1, re2, hz, e_hz, e_rdy, cap;
        in_valid_i = v; inst_i = inst; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
        out_ready_i = rdy; flush_i = fl; rst = rs;
        #1;
        model(inst, pc, r1, r2, b, re1, re2, hz);
        e_hz  = v & hz;
        e_rdy = !e_hz && (exp_q.size() == 0 || rdy);
        chk("hazard_o", 32'(hazard_o), 32'(e_hz));
        chk("in_ready_o", 32'(in_ready_o), 32'(e_rdy));
        chk("rs_re", 32'({rs1_re_o, rs2_re_o}), 32'({re1, re2}));
        chk("rs_addr", 32'({rs1_addr_o, rs2_addr_o}), 32'({inst[19:15], inst[24:20]}));
        cap = v && e_rdy && !fl && !rs;
        if (rs) nhaz = 0;
        else if (e_hz) nhaz++;
        @(posedge clk);
        #1;
        if (rs || fl) begin
            exp_q.delete();
            chk("kill_valid_alusel_wreg", 32'({out_valid_o, alusel_o, wreg_o}), 32'd0);
            if (rs) chk("rst_bundle", opr1_o | opr2_o | opr3_o | opr4_o | 32'(wd_o), 32'd0);
        end else if (cap) begin
            exp_q.push_back(b);
        end
    endtask

    // Monitor: one negedge per cycle; pop on transfer, peek while held
    initial begin
        bun_t d;
        forever begin
            @(negedge clk);
            chk("out_valid_o", 32'(out_valid_o), 32'(exp_q.size() != 0));
            if (out_valid_o && exp_q.size() != 0) begin
                d = '{alusel_o, opr1_o, opr2_o, opr3_o, opr4_o, wd_o, wreg_o};
                nvec++;
                if (d !== exp_q[0]) begin
                    nerr++;
                    $display("FAIL bundle: got %h expected %h", d, exp_q[0]);
                end
                if (out_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] rnd_inst();
        logic [31:0] i = $urandom;
        case ($urandom_range(0, 9))
            0: i[6:0] = 7'h13;  1: i[6:0] = 7'h33;  2: i[6:0] = 7'h37;  3: i[6:0] = 7'h17;
            4: i[6:0] = 7'h6f;  5: i[6:0] = 7'h67;  6: i[6:0] = 7'h63;  7: i[6:0] = 7'h03;
            8: i[6:0] = 7'h23;  default: i[6:0] = 7'h7f;
        endcase
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        i[11:7]  = 5'($urandom_range(0, 7));
        return i;
    endfunction

    localparam logic [31:0] ADDI = 32'hFFD0_0293;  // addi x5,x0,-3
    localparam logic [31:0] ADD  = 32'h0020_81B3;  // add  x3,x1,x2
    localparam logic [31:0] SW   = 32'h0043_2423;  // sw   x4,8(x6)
    localparam logic [31:0] BEQ  = 32'h0020_8063;  // beq  x1,x2,0
    localparam logic [31:0] ADD0 = 32'h0000_03B3;  // add  x7,x0,x0

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        pc_i = '0; inst_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        setf(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00);
        @(posedge clk);
        #1;
        step(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        step(ADDI, 32'h100, 32'h99, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("addi_opr2", opr2_o, 32'hFFFF_FFFD);
        chk("addi_wd_wreg", 32'({wd_o, wreg_o}), 32'({5'd5, 1'b1}));

        setf(2'b11, 5'd1, 5'd1, 32'h22, 32'h11, 2'b00);
        step(ADD, 32'h104, 32'h99, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        setf(2'b11, 5'd2, 5'd1, 32'h33, 32'h11, 2'b00);
        step(ADD, 32'h108, 32'h99, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("fwd_opr12", opr1_o ^ opr2_o, 32'h11 ^ 32'h33);

        setf(2'b01, 5'd0, 5'd4, 32'd0, 32'h0, 2'b01);
        step(SW, 32'h10c, 32'h60, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        setf(2'b01, 5'd0, 5'd4, 32'd0, 32'h55, 2'b00);
        step(SW, 32'h10c, 32'h60, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("loaduse_opr2", opr2_o, 32'h55);
        chk("loaduse_opr3", opr3_o, 32'd8);

        setf(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00);
        step(ADDI, 32'h200, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            step(ADD, 32'h204, 32'h3, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        step(ADD, 32'h204, 32'h3, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);

        step(BEQ, 32'h300, 32'h5, 32'h6, 1'b1, 1'b0, 1'b1, 1'b0);
        step(ADDI, 32'h304, 32'h5, 32'h6, 1'b1, 1'b0, 1'b0, 1'b0);
        step(ADD, 32'h308, 32'h5, 32'h6, 1'b1, 1'b0, 1'b0, 1'b1);

        setf(2'b01, 5'd0, 5'd0, 32'd0, 32'hDEAD, 2'b01);
        step(ADD0, 32'h400, 32'h7, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("x0_opr", opr1_o | opr2_o, 32'd0);

        for (int n = 0; n < 1500; n++) begin
            for (int s = 0; s < NUM_FWD; s++) begin
                fwd_we_i[s]          = 1'($urandom_range(0, 1));
                fwd_wd_i[s*5 +: 5]   = 5'($urandom_range(0, 3));
                fwd_data_i[s*32 +: 32] = $urandom;
                fwd_isload_i[s]      = ($urandom_range(0, 3) == 0);
            end
            step(rnd_inst(), $urandom, $urandom, $urandom, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0);
        end
        step(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ID_STALL_STATS_EN
        chk("stall_cnt_o", stall_cnt_o, 32'(nhaz));
`endif
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Registered decode/operand-issue stage for the RV32I pipeline. Sits between the IF/ID latch and EX.
- Decodes the instruction, reads the regfile and resolves operands from a parametrised number of forwarding sources.
- Detects load-use hazards and stalls on them.
- Holds the decoded bundle in an ID/EX output register with valid/ready handshaking and branch flush.

Parameters:
- XLEN, 32, datapath/operand width.
- REG_AW, 5, register address width.
- NUM_FWD, 2, number of forwarding sources. Index 0 is the youngest (EX), higher indices are older (MEM, WB...).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  branch interception. Kills the held output and the current input.
- in_valid_i  in  1  pc_i/inst_i are valid.
- in_ready_o  out  1  stage accepts the input this cycle.
- pc_i  in  XLEN  instruction address.
- inst_i  in  32  instruction word.
- rs1_re_o, rs2_re_o  out  1  regfile read enables.
- rs1_addr_o, rs2_addr_o  out  REG_AW  regfile read addresses.
- rs1_data_i, rs2_data_i  in  XLEN  regfile read data, same-cycle.
- fwd_we_i  in  NUM_FWD  per-source write enable.
- fwd_wd_i  in  NUM_FWD*REG_AW  per-source destination register.
- fwd_data_i  in  NUM_FWD*XLEN  per-source result.
- fwd_isload_i  in  NUM_FWD  per-source: result not yet available (load in flight).
- out_valid_o  out  1  ID/EX bundle valid.
- out_ready_i  in  1  EX consumes the bundle.
- alusel_o  out  5  ALU select. Bits [2:0] are funct3; bits [4:3] are the class, or a full SEL_* code.
- opr1_o, opr2_o  out  XLEN  operands.
- opr3_o  out  XLEN  immediate when both rs1 and rs2 are read, else 0.
- opr4_o  out  XLEN  pc.
- wd_o  out  REG_AW  destination register.
- wreg_o  out  1  destination write enable.
- hazard_o  out  1  load-use stall asserted this cycle.

Behaviour:
- **Decode** (combinational, from inst_i):
  - OP-IMM: rs1, imm I, write.
  - OP: rs1, rs2, write.
  - LUI, AUIPC: imm U, write.
  - JAL: imm J, write.
  - JALR: rs1, imm I, write.
  - BRANCH: rs1, rs2, imm B, no write.
  - LOAD: rs1, imm I, write.
  - STORE: rs1, rs2, imm S, no write. funct3 values other than 000/001/010 decode as a bubble.
  - Unknown opcode: alusel=0, wreg=0, no reads.
  - All immediates are sign-extended to XLEN.
- **Operand resolve**, per rs, first match wins:
  1. Not read: use imm.
  2. Address 0: use 0. Never forwarded, never a hazard.
  3. Lowest index i with fwd_we_i[i] and fwd_wd_i[i]==addr: if fwd_isload_i[i], hazard; else fwd_data_i[i].
  4. No match: regfile data.
- hazard = in_valid_i & (rs1 hazard | rs2 hazard).
- **Handshake:**
  - in_ready_o = !hazard & (!out_valid_o | out_ready_i).
  - The input is captured when in_valid_i & in_ready_o & !flush_i.
  - Latency: 1 cycle, input to out_valid_o.
- **Output register:**
  - On capture: load the bundle and set out_valid_o=1.
  - Else if out_ready_i: out_valid_o=0.
  - Else: hold all outputs stable.
- **Flush** has priority over capture and hold. Next cycle: out_valid_o=0, wreg_o=0, alusel_o=0.
- **Reset:** all registered outputs are 0, including out_valid_o. rst has priority over flush.
- **Simultaneous hazard and out_ready_i:** the held bundle drains; the next cycle shows out_valid_o=0 (bubble).

Optional Feature:
- Macro: ID_STALL_STATS_EN.
- When defined:
  - Adds output stall_cnt_o, 32 bits.
  - Counts cycles with hazard_o=1 and increments by 1 per such cycle.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst; unaffected by flush.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (defines):
  - opcode constants: EXE_OP_IMM, EXE_OP, EXE_LUI, EXE_AUIPC, EXE_JAL, EXE_JALR, EXE_BRANCH, EXE_LOAD, EXE_STORE;
  - SEL_* ALU-select codes;
  - class encodings.
- One sub-module, id_fwd_mux:
  - one instance per source operand;
  - inputs: read enable, address, regfile data, imm and the forwarding vectors;
  - outputs: operand and hazard.

Test Plan:
- **Hazard-free ADDI.** addi x5,x0,-3 with no forwarding active, out_ready_i=1 → next cycle out_valid_o=1, opr1_o=0, opr2_o=32'hFFFF_FFFD, wd_o=5, wreg_o=1.
- **Forwarding priority.** add x3,x1,x2; source 0 writes x1=0x11, source 1 writes x1=0x22 and x2=0x33, regfile returns 0x99 → opr1_o=0x11, opr2_o=0x33.
- **Load-use stall.** lw x4 in source 0 (isload=1), then sw x4,8(x6) → hazard_o=1, in_ready_o=0 and no capture. Next cycle isload=0 with data 0x55 → captured; opr2_o=0x55, opr3_o=8.
- **Backpressure.** out_ready_i=0 for 3 cycles with a valid bundle held → outputs are unchanged and in_ready_o=0. Release → the new input is captured the following cycle.
- **Flush.** Flush coincident with a valid beq input → next cycle out_valid_o=0, wreg_o=0, alusel_o=0. A mid-operation rst gives all outputs 0.
- **x0 handling.** Source 0 writes x0 with isload=1 and the instruction reads x0 → no hazard, operand 0.
